serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl_if.sv | 41 ++++
 rtl/serial_add_ctrl.sv | 125 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_if.sv
// Request/result and shared full-adder signals of the bit-serial adder sequencer.
// With SERIAL_ADD_SUB_EN defined the bundle also carries the subtract request.
interface serial_add_ctrl_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             fa_a;
  logic             fa_b;
  logic             fa_cin;
  logic             fa_s;
  logic             fa_cout;

`ifdef SERIAL_ADD_SUB_EN
  modport slave (
    input  start, a, b, c_in, sub, fa_s, fa_cout,
    output ready, busy, done, sum, c_out, fa_a, fa_b, fa_cin
  );
  modport master (
    output start, a, b, c_in, sub, fa_s, fa_cout,
    input  ready, busy, done, sum, c_out, fa_a, fa_b, fa_cin
  );
`else
  modport slave (
    input  start, a, b, c_in, fa_s, fa_cout,
    output ready, busy, done, sum, c_out, fa_a, fa_b, fa_cin
  );
  modport master (
    output start, a, b, c_in, fa_s, fa_cout,
    input  ready, busy, done, sum, c_out, fa_a, fa_b, fa_cin
  );
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer driving one shared external full adder, LSB first.
// Optional SERIAL_ADD_SUB_EN adds a sub request (b inverted, carry forced to 1).
//
// state  | meaning
// IDLE   | ready for start, operands captured on accepted start
// RUN    | one operand bit per cycle through the full adder
// DONE   | one-cycle done pulse, result registers valid
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_add_ctrl_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic [WIDTH-1:0] acc_shift;

  logic ready_o, busy_o, done_o, fa_a_o, fa_b_o, fa_cin_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    // Shift-then-insert form also covers WIDTH=1, where acc has no upper slice.
    acc_shift = acc_q >> 1;
    acc_shift[WIDTH-1] = bus.fa_s;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          carry_d = bus.c_in;
`ifdef SERIAL_ADD_SUB_EN
          if (bus.sub) begin
            b_sh_d  = ~bus.b;
            carry_d = 1'b1;
          end
`endif
          cnt_d   = '0;
          acc_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d   = acc_shift;
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = bus.fa_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          sum_d   = acc_shift;
          c_out_d = bus.fa_cout;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready_o  = (state_q == S_IDLE);
    busy_o   = (state_q == S_RUN);
    done_o   = (state_q == S_DONE);
    fa_a_o   = 1'b0;
    fa_b_o   = 1'b0;
    fa_cin_o = 1'b0;
    if (state_q == S_RUN) begin
      fa_a_o   = a_sh_q[0];
      fa_b_o   = b_sh_q[0];
      fa_cin_o = carry_q;
    end
  end

  assign bus.ready  = ready_o;
  assign bus.busy   = busy_o;
  assign bus.done   = done_o;
  assign bus.fa_a   = fa_a_o;
  assign bus.fa_b   = fa_b_o;
  assign bus.fa_cin = fa_cin_o;
  assign bus.sum    = sum_q;
  assign bus.c_out  = c_out_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: WIDTH=8 and WIDTH=1 instances against an arithmetic model.
// Honours SERIAL_ADD_SUB_EN when defined (adds subtract vectors).
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(W)) bus8 ();
  serial_add_ctrl_if #(.WIDTH(1)) bus1 ();

  // Shared full-adder cells modelled by the bench
  assign bus8.fa_s    = bus8.fa_a ^ bus8.fa_b ^ bus8.fa_cin;
  assign bus8.fa_cout = (bus8.fa_a & bus8.fa_b) | (bus8.fa_cin & (bus8.fa_a ^ bus8.fa_b));
  assign bus1.fa_s    = bus1.fa_a ^ bus1.fa_b ^ bus1.fa_cin;
  assign bus1.fa_cout = (bus1.fa_a & bus1.fa_b) | (bus1.fa_cin & (bus1.fa_a ^ bus1.fa_b));

  serial_add_ctrl #(.WIDTH(W)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  serial_add_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  int total = 0;
  int bad   = 0;
  logic [W-1:0] prev_sum;
  logic         prev_c;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready8();
    int n = 0;
    while (bus8.ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check("ready_wait", bus8.ready, 1);
  endtask

  // One WIDTH=8 operation; glitch>=0 pulses start with a=F0 during that RUN cycle.
  task automatic add8(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      input logic sub, input int glitch);
    logic [W-1:0] bb;
    logic         c0;
    longint       full, m, cexp;
    bb   = sub ? ~b : b;
    c0   = sub ? 1'b1 : cin;
    full = longint'(a) + longint'(bb) + longint'(c0);
    wait_ready8();
    bus8.a = a; bus8.b = b; bus8.c_in = cin;
`ifdef SERIAL_ADD_SUB_EN
    bus8.sub = sub;
`endif
    bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    bus8.a = W'($urandom); bus8.b = W'($urandom); bus8.c_in = 1'($urandom);
    for (int i = 0; i < W; i++) begin
      m    = (longint'(1) << i) - 1;
      cexp = ((longint'(a) & m) + (longint'(bb) & m) + longint'(c0)) >> i;
      check("run_busy", bus8.busy, 1);
      check("run_ready", bus8.ready, 0);
      check("run_done", bus8.done, 0);
      check("fa_a", bus8.fa_a, a[i]);
      check("fa_b", bus8.fa_b, bb[i]);
      check("fa_cin", bus8.fa_cin, 32'(cexp & 1));
      check("sum_held_run", bus8.sum, prev_sum);
      check("cout_held_run", bus8.c_out, prev_c);
      if (i == glitch) begin
        bus8.start = 1'b1;
        bus8.a = 8'hF0;
      end
      step();
      bus8.start = 1'b0;
    end
    check("done_pulse", bus8.done, 1);
    check("done_busy", bus8.busy, 0);
    check("done_ready", bus8.ready, 0);
    check("sum", bus8.sum, 32'(full & 'hFF));
    check("c_out", bus8.c_out, 32'((full >> W) & 1));
    check("done_fa_a", bus8.fa_a, 0);
    step();
    check("idle_ready", bus8.ready, 1);
    check("idle_done", bus8.done, 0);
    check("idle_sum_held", bus8.sum, 32'(full & 'hFF));
    check("idle_fa_cin", bus8.fa_cin, 0);
    prev_sum = W'(full);
    prev_c   = 1'(full >> W);
  endtask

  task automatic add1(input logic a, input logic b, input logic cin);
    int s;
    s = int'(a) + int'(b) + int'(cin);
    check("w1_ready", bus1.ready, 1);
    bus1.a = a; bus1.b = b; bus1.c_in = cin; bus1.start = 1'b1;
    step();
    bus1.start = 1'b0;
    check("w1_busy", bus1.busy, 1);
    check("w1_fa_a", bus1.fa_a, a);
    check("w1_fa_cin", bus1.fa_cin, cin);
    step();
    check("w1_done", bus1.done, 1);
    check("w1_sum", bus1.sum, s & 1);
    check("w1_cout", bus1.c_out, s >> 1);
    step();
    check("w1_ready_again", bus1.ready, 1);
  endtask

  initial begin
    rst = 1'b1;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.c_in = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.c_in = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    bus8.sub = 1'b0;
    bus1.sub = 1'b0;
`endif
    prev_sum = '0;
    prev_c   = 1'b0;
    #22;
    check("rst_ready", bus8.ready, 1);
    check("rst_busy", bus8.busy, 0);
    check("rst_done", bus8.done, 0);
    check("rst_sum", bus8.sum, 0);
    check("rst_cout", bus8.c_out, 0);
    check("rst_fa", {bus8.fa_a, bus8.fa_b, bus8.fa_cin}, 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    add8(8'h5A, 8'h3C, 1'b0, 1'b0, -1);
    add8(8'hFF, 8'h01, 1'b0, 1'b0, -1);
    add8(8'h01, 8'h01, 1'b0, 1'b0, 2);
    add8(8'h00, 8'h00, 1'b1, 1'b0, 7);
    add8(8'hFF, 8'hFF, 1'b1, 1'b0, -1);

    // Reset during the fourth RUN cycle
    wait_ready8();
    bus8.a = 8'h33; bus8.b = 8'h11; bus8.c_in = 1'b0; bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    step(); step(); step();
    check("pre_abort_busy", bus8.busy, 1);
    rst = 1'b1;
    #1;
    check("abort_busy", bus8.busy, 0);
    check("abort_done", bus8.done, 0);
    check("abort_ready", bus8.ready, 1);
    check("abort_sum", bus8.sum, 0);
    check("abort_cout", bus8.c_out, 0);
    check("abort_fa", {bus8.fa_a, bus8.fa_b, bus8.fa_cin}, 0);
    step();
    check("abort_no_done", bus8.done, 0);
    @(negedge clk);
    rst = 1'b0;
    prev_sum = '0;
    prev_c   = 1'b0;
    step();
    add8(8'h33, 8'h11, 1'b0, 1'b0, -1);

`ifdef SERIAL_ADD_SUB_EN
    add8(8'h10, 8'h20, 1'b0, 1'b1, -1);
    add8(8'h20, 8'h10, 1'b1, 1'b1, -1);
`endif

    for (int r = 0; r < 20; r++) begin
      logic s;
`ifdef SERIAL_ADD_SUB_EN
      s = 1'($urandom);
`else
      s = 1'b0;
`endif
      add8(W'($urandom), W'($urandom), 1'($urandom), s, int'($urandom_range(0, 9)) - 2);
    end

    add1(1'b1, 1'b1, 1'b1);
    add1(1'b1, 1'b0, 1'b0);
    for (int r = 0; r < 4; r++)
      add1(1'($urandom), 1'($urandom), 1'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
